// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared constants, state encoding and helpers for the RV32M multiply/divide sequencer
package mdu_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_e;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Magnitude of a value; 32'h8000_0000 stays 32'h8000_0000 read as unsigned
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_step.sv
// rtl/mdu_sequencer_step.sv - one combinational radix-2 iteration (shift-add multiply / restoring divide)
module mdu_sequencer_step
    import mdu_sequencer_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_in,
    input  logic [XLEN-1:0] opr_in,
    input  logic [XLEN-1:0] mag_in,
    output logic [XLEN-1:0] acc_out,
    output logic [XLEN-1:0] opr_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiply: acc:opr is the running product, opr shifts out multiplier bits.
    // Divide: acc is the partial remainder, opr shifts dividend bits out and quotient bits in.
    always_comb begin
        sum     = {1'b0, acc_in} + (opr_in[0] ? {1'b0, mag_in} : {(XLEN+1){1'b0}});
        shifted = {acc_in, opr_in[XLEN-1]};
        diff    = shifted - {1'b0, mag_in};
        acc_out = sum[XLEN:1];
        opr_out = {sum[0], opr_in[XLEN-1:1]};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = diff[XLEN-1:0];
                opr_out = {opr_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = shifted[XLEN-1:0];
                opr_out = {opr_in[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle RV32M multiply/divide controller with pipeline stall (optional MDU_EARLY_OUT_EN)
module mdu_sequencer
    import mdu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    mdu_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] opr;
    logic [XLEN-1:0] mag;
    logic [XLEN-1:0] a_save;
    logic [2:0]      f3_q;
    logic            sa;
    logic            sb;
    logic            a_zero;
    logic            b_zero;

    logic            accept;
    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] opr_nx;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    assign accept = start && (state == ST_IDLE) && !flush;
    assign stall  = accept || busy;
    assign abs_a  = magnitude(op_a, a_is_signed(funct3));
    assign abs_b  = magnitude(op_b, b_is_signed(funct3));

`ifdef MDU_EARLY_OUT_EN
    logic early_skip;
    assign early_skip = funct3[2] ? (op_b == '0) : ((op_a == '0) || (op_b == '0));
`endif

    mdu_sequencer_step u_step (
        .is_div  (f3_q[2]),
        .acc_in  (acc),
        .opr_in  (opr),
        .mag_in  (mag),
        .acc_out (acc_nx),
        .opr_out (opr_nx)
    );

    // Sign correction and result selection applied in FIXUP
    always_comb begin
        prod    = {acc, opr};
        if (sa ^ sb) begin
            prod = ~prod + 1'b1;
        end
        quo     = (sa ^ sb) ? (~opr + 1'b1) : opr;
        rem     = sa ? (~acc + 1'b1) : acc;
        fix_res = '0;
        if (!f3_q[2]) begin
            if (a_zero || b_zero) begin
                fix_res = '0;
            end else if (f3_q == F3_MUL) begin
                fix_res = prod[XLEN-1:0];
            end else begin
                fix_res = prod[2*XLEN-1:XLEN];
            end
        end else if (b_zero) begin
            // Divide by zero: quotient all ones, remainder is the original dividend
            fix_res = f3_q[1] ? a_save : '1;
        end else begin
            fix_res = f3_q[1] ? rem : quo;
        end
    end

    // Control FSM: accept, iterate, fix up, present result for one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opr    <= '0;
            mag    <= '0;
            a_save <= '0;
            f3_q   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            a_zero <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q   <= funct3;
                        sa     <= a_is_signed(funct3) && op_a[XLEN-1];
                        sb     <= b_is_signed(funct3) && op_b[XLEN-1];
                        a_zero <= (op_a == '0);
                        b_zero <= (op_b == '0);
                        a_save <= op_a;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (funct3[2]) begin
                            opr <= abs_a;
                            mag <= abs_b;
                        end else begin
                            opr <= abs_b;
                            mag <= abs_a;
                        end
`ifdef MDU_EARLY_OUT_EN
                        state <= early_skip ? ST_FIXUP : ST_CALC;
`else
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_nx;
                        opr <= opr_nx;
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            cnt   <= '0;
                            state <= ST_FIXUP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_FIXUP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall;

    int vec;
    int errs;

`ifdef MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    mdu_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at a negedge and wait for done; lat = cycles from accept cycle, -1 on timeout
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic stall_ok);
        lat = -1;
        res = 'x;
        @(negedge clk);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (done === 1'b1) begin
                lat = n;
                res = result;
                stall_ok = stall_ok && (stall === 1'b0);
                break;
            end
            stall_ok = stall_ok && (stall === 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0)    begin errs++; $display("FAIL reset_done got %b want 0", done); end
        vec++; if (result !== 32'h0) begin errs++; $display("FAIL reset_result got %h want 0", result); end
        vec++; if (stall !== 1'b0)   begin errs++; $display("FAIL reset_stall got %b want 0", stall); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_table(input string name, input logic [2:0] f3s [4], input logic [31:0] as [4],
                              input logic [31:0] bs [4], input logic [31:0] exps [4], input int lats [4]);
        int lat;
        logic [31:0] res;
        logic sok;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, res, sok);
            vec++; if (lat != lats[i]) begin errs++; $display("FAIL %s[%0d]_latency got %0d want %0d", name, i, lat, lats[i]); end
            vec++; if (res !== exps[i]) begin errs++; $display("FAIL %s[%0d]_result got %h want %h", name, i, res, exps[i]); end
            vec++; if (!sok) begin errs++; $display("FAIL %s[%0d]_stall got bad window want high until done", name, i); end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
        logic [31:0] a [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] e [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
        int          l [4] = '{34, 34, 34, 34};
        test_table("mul", f, a, b, e, l);
    endtask

    task automatic test_div();
        logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int          l [4] = '{34, 34, 34, 34};
        test_table("div", f, a, b, e, l);
    endtask

    task automatic test_mul_zero();
        logic [2:0]  f [4] = '{3'b000, 3'b011, 3'b001, 3'b000};
        logic [31:0] a [4] = '{32'd0, 32'h1234_5678, 32'd0, 32'd6};
        logic [31:0] b [4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] e [4] = '{32'd0, 32'd0, 32'd0, 32'd54};
        int          l [4] = '{EARLY_LAT, EARLY_LAT, EARLY_LAT, 34};
        test_table("mulzero", f, a, b, e, l);
    endtask

    task automatic test_div_zero();
        logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] a [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] b [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] e [4] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        int          l [4] = '{34, 34, EARLY_LAT, EARLY_LAT};
        test_table("divzero", f, a, b, e, l);
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        logic        saw_done;
        prev = result;
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        #1;
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL flush_busy_mid got %b want 1", busy); end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vec++; if (busy !== 1'b0)  begin errs++; $display("FAIL flush_busy got %b want 0", busy); end
        vec++; if (stall !== 1'b0) begin errs++; $display("FAIL flush_stall got %b want 0", stall); end
        saw_done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        vec++; if (saw_done)       begin errs++; $display("FAIL flush_no_done got 1 want 0"); end
        vec++; if (result !== prev) begin errs++; $display("FAIL flush_result got %h want %h", result, prev); end
        start = 1'b1; flush = 1'b1;
        #1;
        vec++; if (stall !== 1'b0) begin errs++; $display("FAIL start_flush_stall got %b want 0", stall); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        vec++; if (busy !== 1'b0)  begin errs++; $display("FAIL start_flush_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        vec++; if (result === 32'h0) begin errs++; $display("FAIL reset_mid_precondition got %h want nonzero", result); end
        @(negedge clk);
        funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vec++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        vec++; if (done !== 1'b0)    begin errs++; $display("FAIL reset_mid_done got %b want 0", done); end
        vec++; if (result !== 32'h0) begin errs++; $display("FAIL reset_mid_result got %h want 0", result); end
        vec++; if (stall !== 1'b0)   begin errs++; $display("FAIL reset_mid_stall got %b want 0", stall); end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        vec++; if (saw_done) begin errs++; $display("FAIL reset_mid_no_done got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int dlat;
        logic got;
        run_op(3'b101, 32'd100, 32'd7, lat, op_a, got);
        vec++; if (lat != 34) begin errs++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
        funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        #1;
        vec++; if (stall !== 1'b0) begin errs++; $display("FAIL b2b_done_cycle_stall got %b want 0", stall); end
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd5; op_b = 32'd7; start = 1'b1;
        #1;
        vec++; if (stall !== 1'b1) begin errs++; $display("FAIL b2b_accept_stall got %b want 1", stall); end
        @(negedge clk);
        start = 1'b0;
        dlat = -1;
        for (int n = 2; n <= 80; n++) begin
            if (done === 1'b1) begin
                dlat = n;
                break;
            end
            @(negedge clk);
        end
        vec++; if (dlat != 35) begin errs++; $display("FAIL b2b_second_latency got %0d want 35", dlat); end
        vec++; if (result !== 32'd35) begin errs++; $display("FAIL b2b_result got %h want %h", result, 32'd35); end
    endtask

    initial begin
        vec    = 0;
        errs   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;
        test_reset();
        test_mul();
        test_div();
        test_mul_zero();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
